// File: rtl/bitpack_pkg.sv
// ============================================================================
// Module      : bitpack_pkg
// Description : Shared sizing constants and state encoding for bitpack_stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitpack_pkg;

    localparam int LANES_DEF = 2;
    localparam int CW_DEF    = 63;
    localparam int BCW_DEF   = 6;
    localparam int OW_DEF    = 64;

    localparam int MW   = LANES_DEF * CW_DEF;
    localparam int BUFW = OW_DEF + MW;
    localparam int MCW  = $clog2(MW + 1);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bitpack_merge.sv
// ============================================================================
// Module      : bitpack_merge
// Description : Registered LANES-way merge of MSB-aligned codes into one run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitpack_merge
    import bitpack_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int CW    = CW_DEF,
    parameter int BCW   = BCW_DEF,
    parameter int MRG_W = LANES * CW,
    parameter int MCN_W = $clog2(MRG_W + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_en,
    input  logic                   i_flush,
    input  logic                   i_hold,
    input  logic [LANES*CW-1:0]    i_bv,
    input  logic [LANES*BCW-1:0]   i_bc,
    output logic                   o_valid,
    output logic                   o_flush,
    output logic [MRG_W-1:0]       o_bv,
    output logic [MCN_W-1:0]       o_bc
);

    logic [CW-1:0]    w_field;
    logic [BCW-1:0]   w_cnt;
    logic [MRG_W-1:0] w_ext;
    logic [MRG_W-1:0] w_bv;
    logic [MCN_W-1:0] w_bc;

    logic             r_valid;
    logic             r_flush;
    logic [MRG_W-1:0] r_bv;
    logic [MCN_W-1:0] r_bc;

    // Each lane is masked to its declared length so stray low bits never leak.
    always_comb begin
        w_field = '0;
        w_cnt   = '0;
        w_ext   = '0;
        w_bv    = '0;
        w_bc    = '0;
        for (int k = 0; k < LANES; k++) begin
            w_field = i_bv[(LANES-k)*CW-1 -: CW];
            w_cnt   = i_bc[(LANES-k)*BCW-1 -: BCW];
            w_field = w_field & ~({CW{1'b1}} >> w_cnt);
            w_ext   = '0;
            w_ext[MRG_W-1 -: CW] = w_field;
            w_bv    = w_bv | (w_ext >> w_bc);
            w_bc    = w_bc + MCN_W'(w_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_bv    <= '0;
            r_bc    <= '0;
        end else if (!i_hold) begin
            r_valid <= i_en;
            r_flush <= i_en && i_flush;
            if (i_en) begin
                r_bv <= w_bv;
                r_bc <= w_bc;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_flush = r_flush;
    assign o_bv    = r_bv;
    assign o_bc    = r_bc;

endmodule

`default_nettype wire

// File: rtl/bitpack_stream.sv
// ============================================================================
// Module      : bitpack_stream
// Description : Packs merged lane codes into OW-bit words with flush/last tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitpack_stream
    import bitpack_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int CW    = CW_DEF,
    parameter int BCW   = BCW_DEF,
    parameter int OW    = OW_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_en,
    output logic                 i_ready,
    input  logic [LANES*CW-1:0]  i_bv,
    input  logic [LANES*BCW-1:0] i_bc,
    input  logic                 i_flush,
    output logic                 o_en,
    input  logic                 o_ready,
    output logic [OW-1:0]        o_data,
    output logic                 o_last
);

    localparam int MRG_W = LANES * CW;
    localparam int MCN_W = $clog2(MRG_W + 1);
    localparam int BUF_W = OW + MRG_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] C_OW_CNT = CNT_W'(OW);

    logic             w_m_valid;
    logic             w_m_flush;
    logic [MRG_W-1:0] w_m_bv;
    logic [MCN_W-1:0] w_m_bc;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_oen;
    logic [OW-1:0]    r_odata;
    logic             r_olast;

    logic             w_slot;
    logic             w_absorb;
    logic             w_emit;
    logic             w_emit_last;

    bitpack_merge #(
        .LANES (LANES),
        .CW    (CW),
        .BCW   (BCW),
        .MRG_W (MRG_W),
        .MCN_W (MCN_W)
    ) u_merge (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (i_en && i_ready),
        .i_flush (i_flush),
        .i_hold  (w_m_valid && !w_absorb),
        .i_bv    (i_bv),
        .i_bc    (i_bc),
        .o_valid (w_m_valid),
        .o_flush (w_m_flush),
        .o_bv    (w_m_bv),
        .o_bc    (w_m_bc)
    );

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_absorb && w_m_flush)    w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_slot && r_cnt <= C_OW_CNT) w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Absorb needs cnt<OW and a normal emit needs cnt>=OW, so they never coincide.
    always_comb begin
        w_slot      = !r_oen || o_ready;
        w_absorb    = 1'b0;
        w_emit      = 1'b0;
        w_emit_last = 1'b0;
        case (r_state)
            S_RUN: begin
                w_absorb = w_m_valid && (r_cnt < C_OW_CNT);
                w_emit   = (r_cnt >= C_OW_CNT) && w_slot;
            end
            S_FLUSH: begin
                w_emit      = w_slot;
                w_emit_last = w_slot && (r_cnt <= C_OW_CNT);
            end
            default: ;
        endcase
        i_ready = (r_state == S_RUN) && !(w_m_valid && w_m_flush)
                  && (!w_m_valid || (r_cnt < C_OW_CNT));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_oen   <= 1'b0;
            r_odata <= '0;
            r_olast <= 1'b0;
        end else if (w_emit) begin
            r_odata <= r_buf[BUF_W-1 -: OW];
            r_buf   <= r_buf << OW;
            r_cnt   <= w_emit_last ? '0 : (r_cnt - C_OW_CNT);
            r_oen   <= 1'b1;
            r_olast <= w_emit_last;
        end else begin
            if (o_ready) begin
                r_oen   <= 1'b0;
                r_olast <= 1'b0;
            end
            if (w_absorb) begin
                r_buf <= r_buf | ({w_m_bv, {OW{1'b0}}} >> r_cnt);
                r_cnt <= r_cnt + CNT_W'(w_m_bc);
            end
        end
    end

    assign o_en   = r_oen;
    assign o_data = r_odata;
    assign o_last = r_olast;

endmodule

`default_nettype wire

// File: tb/tb_bitpack_stream.sv
// ============================================================================
// Module      : tb_bitpack_stream
// Description : Directed scoreboard bench for bitpack_stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bitpack_stream;

    localparam int LANES = 2;
    localparam int CW    = 63;
    localparam int BCW   = 6;
    localparam int OW    = 64;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 i_en = 1'b0;
    logic                 i_ready;
    logic [LANES*CW-1:0]  i_bv = '0;
    logic [LANES*BCW-1:0] i_bc = '0;
    logic                 i_flush = 1'b0;
    logic                 o_en;
    logic                 o_ready = 1'b1;
    logic [OW-1:0]        o_data;
    logic                 o_last;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic drv_done;

    always #5 clk = ~clk;

    bitpack_stream #(.LANES(LANES), .CW(CW), .BCW(BCW), .OW(OW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (i_en),
        .i_ready (i_ready),
        .i_bv    (i_bv),
        .i_bc    (i_bc),
        .i_flush (i_flush),
        .o_en    (o_en),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input logic [63:0] v, input int bits);
        logic [CW-1:0] f;
        f = CW'(v);
        return f << (CW - bits);
    endfunction

    // Monitor: pops one expectation per handshake and checks stall stability.
    logic [OW-1:0] prev_data = '0;
    logic          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_stall && o_en) check("hold_data", o_data, prev_data);
            if (o_en && o_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected no word", o_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("word_data", o_data, e.data);
                    check("word_last", {63'b0, o_last}, {63'b0, e.last});
                end
            end
            prev_stall = o_en && !o_ready;
            prev_data  = o_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CW-1:0] b0, input int c0,
                        input logic [CW-1:0] b1, input int c1, input logic fl);
        int n;
        n       = 0;
        i_bv    = {b0, b1};
        i_bc    = {BCW'(c0), BCW'(c1)};
        i_flush = fl;
        i_en    = 1'b1;
        while (!i_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!i_ready) check("accept_timeout", {63'b0, i_ready}, 64'd1);
        tick(1);
        i_en    = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        // Reset and idle
        tick(2);
        rstn = 1'b1;
        check("rst_o_en", {63'b0, o_en}, 64'd0);
        check("rst_o_last", {63'b0, o_last}, 64'd0);
        check("rst_o_data", o_data, 64'd0);
        check("rst_i_ready", {63'b0, i_ready}, 64'd1);
        tick(10);
        check("idle_o_en", {63'b0, o_en}, 64'd0);

        // Two full 32-bit lanes, with latency
        q.push_back('{data: 64'hDEADBEEF01234567, last: 1'b0});
        send(mk(64'hDEADBEEF, 32), 32, mk(64'h01234567, 32), 32, 1'b0);
        check("lat_edge1", {63'b0, o_en}, 64'd0);
        tick(1);
        check("lat_edge2", {63'b0, o_en}, 64'd0);
        tick(1);
        check("lat_edge3", {63'b0, o_en}, 64'd1);
        drain();

        // Zero-count beat with garbage bits, then 40 ones with flush
        q.push_back('{data: 64'hFFFFFFFFFF000000, last: 1'b1});
        send({CW{1'b1}}, 0, {CW{1'b1}}, 0, 1'b0);
        send(mk(64'hFF_FFFF_FFFF, 40), 40, '0, 0, 1'b0 | 1'b1);
        drain();
        tick(2);
        check("ready_after_flush", {63'b0, i_ready}, 64'd1);

        // Backpressure with four full beats, then flush the 56-bit tail
        o_ready  = 1'b0;
        drv_done = 1'b0;
        for (int i = 0; i < 7; i++) q.push_back('{data: 64'hFFFFFFFFFFFFFFFF, last: 1'b0});
        q.push_back('{data: 64'hFFFFFFFFFFFFFF00, last: 1'b1});
        fork
            begin
                for (int b = 0; b < 4; b++) send({CW{1'b1}}, 63, {CW{1'b1}}, 63, 1'b0);
                drv_done = 1'b1;
            end
        join_none
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            if (!i_ready) seen = 1'b1;
        end
        check("ready_drop", {63'b0, seen}, 64'd1);
        tick(6);
        check("held_o_en", {63'b0, o_en}, 64'd1);
        check("held_ready", {63'b0, i_ready}, 64'd0);
        o_ready = 1'b1;
        for (int c = 0; c < 300 && !drv_done; c++) tick(1);
        check("drv_done", {63'b0, drv_done}, 64'd1);
        send('0, 0, '0, 0, 1'b1);
        drain();

        // Flush with an empty buffer
        q.push_back('{data: 64'h0, last: 1'b1});
        send('0, 0, '0, 0, 1'b1);
        drain();

        // Reset with a held word and 50 buffered bits
        o_ready = 1'b0;
        send(mk(64'hCAFEBABE, 32), 32, mk(64'h12345678, 32), 32, 1'b0);
        send(mk(64'h3_FFFF_0000_1234, 50), 50, '0, 0, 1'b0);
        tick(4);
        check("pre_rst_o_en", {63'b0, o_en}, 64'd1);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        check("mid_rst_o_en", {63'b0, o_en}, 64'd0);
        check("mid_rst_i_ready", {63'b0, i_ready}, 64'd1);
        o_ready = 1'b1;
        q.push_back('{data: 64'h0123456789ABCDEF, last: 1'b0});
        send(mk(64'h01234567, 32), 32, mk(64'h89ABCDEF, 32), 32, 1'b0);
        drain();
        tick(10);
        check("final_queue", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
